// File: rtl/down_count_sequencer.sv
// -----------------------------------------------------------------------------
// down_count_sequencer
//
// Sequencing controller for a down-counter datapath. A start command loads a
// programmable value, the count then runs down to zero, and the block either
// stops in DONE or reloads the last start value and keeps running. Pause and
// resume freeze and release the count, and abort returns the block to IDLE
// from any state.
//
// Ports:
//   clk          in   rising-edge system clock
//   set          in   synchronous active-high reset, dominates every command
//   load_val     in   start/reload value, used only on an accepted start
//                     from IDLE or DONE
//   start        in   one-cycle command: begin (IDLE/DONE) or resume (PAUSE)
//   pause        in   one-cycle command: freeze the count (RUN only)
//   abort        in   one-cycle command: back to IDLE from any state
//   auto_reload  in   level, looked at in RUN when cnt is zero
//   cnt          out  current count (registered)
//   busy         out  high in RUN and PAUSE
//   tc_pulse     out  one-cycle pulse on the cycle cnt first reaches zero
//   done         out  sticky flag, high while in DONE
//   laps         out  auto-reloads since the last accepted start (wraps)
//   state        out  IDLE=0, RUN=1, PAUSE=2, DONE=3 (debug visibility)
//
// Handshake: there is no valid/ready pairing here. Each command is a
// single-cycle strobe sampled at the rising edge. When several strobes arrive
// in the same cycle, abort wins over pause, and pause wins over start. A
// strobe that does not apply to the current state is dropped. Nothing is
// queued for a later cycle.
// -----------------------------------------------------------------------------
module down_count_sequencer #(
  parameter int                WIDTH          = 4,
  parameter logic [WIDTH-1:0]  RELOAD_DEFAULT = 4'hF,
  parameter int                LAP_W          = 4
) (
  input  logic             clk,
  input  logic             set,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done,
  output logic [LAP_W-1:0] laps,
  output logic [1:0]       state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [WIDTH-1:0] reload_reg;

  logic [1:0]       state_nx;
  logic [WIDTH-1:0] cnt_nx;
  logic [WIDTH-1:0] cnt_dec;
  logic             tc_nx;
  logic [LAP_W-1:0] laps_nx;
  logic [WIDTH-1:0] reload_nx;
  logic             load_nz;
  logic             cnt_zero;

  assign load_nz  = |load_val;
  assign cnt_zero = (cnt == '0);
  assign cnt_dec  = cnt - 1'b1;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    tc_nx     = 1'b0;
    laps_nx   = laps;
    reload_nx = reload_reg;

    case (state)
      S_IDLE: begin
        // abort is a no-op here. A zero start value is refused because it
        // would produce a run with no count.
        if (!abort && start && load_nz) begin
          state_nx  = S_RUN;
          cnt_nx    = load_val;
          reload_nx = load_val;
          laps_nx   = '0;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (pause) begin
          // The count holds and tc is suppressed. The terminal event fires
          // after resume, so it is delayed but never dropped.
          state_nx = S_PAUSE;
        end else if (!cnt_zero) begin
          cnt_nx = cnt_dec;
          tc_nx  = (cnt_dec == '0);
        end else if (auto_reload) begin
          cnt_nx  = reload_reg;
          laps_nx = laps + 1'b1;
        end else begin
          state_nx = S_DONE;
        end
      end

      S_PAUSE: begin
        if (abort) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (start) begin
          // Resume only: load_val is not sampled and cnt holds this cycle.
          state_nx = S_RUN;
        end
      end

      S_DONE: begin
        if (abort) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (start && load_nz) begin
          state_nx  = S_RUN;
          cnt_nx    = load_val;
          reload_nx = load_val;
          laps_nx   = '0;
        end
      end

      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (set) begin
      state      <= S_IDLE;
      cnt        <= '0;
      tc_pulse   <= 1'b0;
      laps       <= '0;
      reload_reg <= RELOAD_DEFAULT;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      tc_pulse   <= tc_nx;
      laps       <= laps_nx;
      reload_reg <= reload_nx;
    end
  end

  // Both flags decode the registered state, so no input reaches them
  // combinationally.
  assign busy = (state == S_RUN) || (state == S_PAUSE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_down_count_sequencer.sv
module tb_down_count_sequencer;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PAU  = 2'd2;
  localparam logic [1:0] DN   = 2'd3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       set;
  logic [3:0] load_val;
  logic       start, pause, abort, auto_reload;
  logic [3:0] cnt;
  logic       busy, tc_pulse, done;
  logic [3:0] laps;
  logic [1:0] state;

  always #5 clk = ~clk;

  down_count_sequencer dut (
    .clk         (clk),
    .set         (set),
    .load_val    (load_val),
    .start       (start),
    .pause       (pause),
    .abort       (abort),
    .auto_reload (auto_reload),
    .cnt         (cnt),
    .busy        (busy),
    .tc_pulse    (tc_pulse),
    .done        (done),
    .laps        (laps),
    .state       (state)
  );

  // Observed vector layout: {state[1:0], cnt[3:0], tc, done, busy, laps[3:0]}
  logic [12:0] obs;
  assign obs = {state, cnt, tc_pulse, done, busy, laps};

  // ---------------- scoreboard ----------------
  logic [8:0]  stim_q[$];
  logic [12:0] exp_q[$];
  logic [12:0] want;
  int total = 0;
  int bad   = 0;

  // Stimulus row layout: {set, start, pause, abort, auto_reload, load_val}
  function automatic logic [8:0] sv(input logic s_set, input logic s_st,
                                    input logic s_ps, input logic s_ab,
                                    input logic s_ar, input logic [3:0] lv);
    return {s_set, s_st, s_ps, s_ab, s_ar, lv};
  endfunction

  function automatic logic [12:0] ev(input logic [1:0] s, input logic [3:0] c,
                                     input logic tc, input logic dn,
                                     input logic bs, input logic [3:0] lp);
    return {s, c, tc, dn, bs, lp};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [8:0] s, input logic [12:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int step = 0;
    add(sv(1, 1, 0, 0, 0, 4'd5), ev(IDLE, 0, 0, 0, 0, 0));
    add(sv(0, 0, 0, 0, 0, 4'd0), ev(IDLE, 0, 0, 0, 0, 0));
    while (stim_q.size() != 0) begin
      {set, start, pause, abort, auto_reload, load_val} = stim_q.pop_front();
      tick();
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL reset step=%0d {st,cnt,tc,dn,bsy,laps} got=%b want=%b", step, obs, want);
      end
      step++;
    end
  endtask

  task automatic test_one_shot();
    int step = 0;
    add(sv(0, 1, 0, 0, 0, 4'd5), ev(RUN, 5, 0, 0, 1, 0));
    for (int k = 1; k <= 5; k++)
      add(sv(0, 0, 0, 0, 0, 0), ev(RUN, 4'(5 - k), (k == 5), 0, 1, 0));
    add(sv(0, 0, 0, 0, 0, 0), ev(DN, 0, 0, 1, 0, 0));
    add(sv(0, 0, 0, 0, 0, 0), ev(DN, 0, 0, 1, 0, 0));
    while (stim_q.size() != 0) begin
      {set, start, pause, abort, auto_reload, load_val} = stim_q.pop_front();
      tick();
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL one_shot step=%0d {st,cnt,tc,dn,bsy,laps} got=%b want=%b", step, obs, want);
      end
      step++;
    end
  endtask

  task automatic test_auto_reload();
    int step = 0;
    int c;
    add(sv(0, 1, 0, 0, 1, 4'd3), ev(RUN, 3, 0, 0, 1, 0));
    for (int j = 1; j <= 11; j++) begin
      c = 3 - (j % 4);
      add(sv(0, 0, 0, 0, 1, 0), ev(RUN, 4'(c), (c == 0), 0, 1, 4'(j / 4)));
    end
    // abort keeps laps
    add(sv(0, 0, 0, 1, 1, 0), ev(IDLE, 0, 0, 0, 0, 2));
    while (stim_q.size() != 0) begin
      {set, start, pause, abort, auto_reload, load_val} = stim_q.pop_front();
      tick();
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL auto_reload step=%0d {st,cnt,tc,dn,bsy,laps} got=%b want=%b", step, obs, want);
      end
      step++;
    end
  endtask

  task automatic test_pause();
    int step = 0;
    add(sv(0, 1, 0, 0, 0, 4'd4), ev(RUN, 4, 0, 0, 1, 0));
    add(sv(0, 0, 0, 0, 0, 0),    ev(RUN, 3, 0, 0, 1, 0));
    add(sv(0, 0, 0, 0, 0, 0),    ev(RUN, 2, 0, 0, 1, 0));
    add(sv(0, 0, 1, 0, 0, 0),    ev(PAU, 2, 0, 0, 1, 0));
    add(sv(0, 0, 0, 0, 0, 0),    ev(PAU, 2, 0, 0, 1, 0));
    add(sv(0, 0, 1, 0, 0, 0),    ev(PAU, 2, 0, 0, 1, 0));
    add(sv(0, 1, 0, 0, 0, 4'd9), ev(RUN, 2, 0, 0, 1, 0));
    add(sv(0, 0, 0, 0, 0, 0),    ev(RUN, 1, 0, 0, 1, 0));
    add(sv(0, 0, 0, 0, 0, 0),    ev(RUN, 0, 1, 0, 1, 0));
    add(sv(0, 0, 0, 0, 0, 0),    ev(DN,  0, 0, 1, 0, 0));
    while (stim_q.size() != 0) begin
      {set, start, pause, abort, auto_reload, load_val} = stim_q.pop_front();
      tick();
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL pause step=%0d {st,cnt,tc,dn,bsy,laps} got=%b want=%b", step, obs, want);
      end
      step++;
    end
  endtask

  task automatic test_same_cycle_cmds();
    int step = 0;
    add(sv(0, 1, 0, 0, 0, 4'd2), ev(RUN,  2, 0, 0, 1, 0));
    add(sv(0, 0, 0, 0, 0, 0),    ev(RUN,  1, 0, 0, 1, 0));
    add(sv(0, 1, 1, 0, 0, 4'd7), ev(PAU,  1, 0, 0, 1, 0));
    add(sv(0, 0, 0, 0, 0, 0),    ev(PAU,  1, 0, 0, 1, 0));
    add(sv(0, 1, 0, 0, 0, 0),    ev(RUN,  1, 0, 0, 1, 0));
    add(sv(0, 0, 0, 0, 0, 0),    ev(RUN,  0, 1, 0, 1, 0));
    add(sv(0, 0, 1, 0, 0, 0),    ev(PAU,  0, 0, 0, 1, 0));
    add(sv(0, 1, 0, 0, 0, 0),    ev(RUN,  0, 0, 0, 1, 0));
    add(sv(0, 0, 0, 0, 0, 0),    ev(DN,   0, 0, 1, 0, 0));
    add(sv(0, 1, 0, 0, 0, 4'd6), ev(RUN,  6, 0, 0, 1, 0));
    add(sv(0, 0, 1, 0, 0, 0),    ev(PAU,  6, 0, 0, 1, 0));
    add(sv(0, 0, 1, 1, 0, 0),    ev(IDLE, 0, 0, 0, 0, 0));
    add(sv(0, 0, 0, 1, 0, 0),    ev(IDLE, 0, 0, 0, 0, 0));
    while (stim_q.size() != 0) begin
      {set, start, pause, abort, auto_reload, load_val} = stim_q.pop_front();
      tick();
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL same_cycle step=%0d {st,cnt,tc,dn,bsy,laps} got=%b want=%b", step, obs, want);
      end
      step++;
    end
  endtask

  task automatic test_load_zero();
    int step = 0;
    add(sv(0, 1, 0, 0, 0, 4'd0), ev(IDLE, 0, 0, 0, 0, 0));
    add(sv(0, 1, 0, 0, 1, 4'd1), ev(RUN,  1, 0, 0, 1, 0));
    add(sv(0, 0, 0, 0, 1, 0),    ev(RUN,  0, 1, 0, 1, 0));
    add(sv(0, 0, 0, 0, 1, 0),    ev(RUN,  1, 0, 0, 1, 1));
    add(sv(0, 0, 0, 0, 0, 0),    ev(RUN,  0, 1, 0, 1, 1));
    add(sv(0, 0, 0, 0, 0, 0),    ev(DN,   0, 0, 1, 0, 1));
    add(sv(0, 1, 0, 0, 0, 4'd0), ev(DN,   0, 0, 1, 0, 1));
    add(sv(0, 1, 0, 0, 0, 4'd2), ev(RUN,  2, 0, 0, 1, 0));
    add(sv(0, 0, 0, 0, 0, 0),    ev(RUN,  1, 0, 0, 1, 0));
    add(sv(0, 0, 0, 1, 0, 0),    ev(IDLE, 0, 0, 0, 0, 0));
    while (stim_q.size() != 0) begin
      {set, start, pause, abort, auto_reload, load_val} = stim_q.pop_front();
      tick();
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL load_zero step=%0d {st,cnt,tc,dn,bsy,laps} got=%b want=%b", step, obs, want);
      end
      step++;
    end
  endtask

  task automatic test_reset_mid_count();
    int step = 0;
    add(sv(0, 1, 0, 0, 0, 4'd9), ev(RUN,  9, 0, 0, 1, 0));
    add(sv(0, 0, 0, 0, 0, 0),    ev(RUN,  8, 0, 0, 1, 0));
    add(sv(0, 0, 0, 0, 0, 0),    ev(RUN,  7, 0, 0, 1, 0));
    add(sv(1, 1, 0, 0, 0, 4'd3), ev(IDLE, 0, 0, 0, 0, 0));
    add(sv(0, 1, 0, 0, 0, 4'd0), ev(IDLE, 0, 0, 0, 0, 0));
    add(sv(0, 1, 0, 0, 1, 4'hF), ev(RUN, 4'hF, 0, 0, 1, 0));
    for (int k = 1; k <= 15; k++)
      add(sv(0, 0, 0, 0, 1, 0), ev(RUN, 4'(15 - k), (k == 15), 0, 1, 0));
    add(sv(0, 0, 0, 0, 1, 0),    ev(RUN, 4'hF, 0, 0, 1, 1));
    add(sv(0, 0, 0, 1, 0, 0),    ev(IDLE, 0, 0, 0, 0, 1));
    while (stim_q.size() != 0) begin
      {set, start, pause, abort, auto_reload, load_val} = stim_q.pop_front();
      tick();
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL reset_mid step=%0d {st,cnt,tc,dn,bsy,laps} got=%b want=%b", step, obs, want);
      end
      step++;
    end
  endtask

  task automatic test_random_one_shot();
    int step = 0;
    int n;
    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(1, 15);
      add(sv(0, 1, 0, 0, 0, 4'(n)), ev(RUN, 4'(n), 0, 0, 1, 0));
      for (int k = 1; k <= n; k++)
        add(sv(0, 0, 0, 0, 0, 0), ev(RUN, 4'(n - k), (k == n), 0, 1, 0));
      add(sv(0, 0, 0, 0, 0, 0), ev(DN, 0, 0, 1, 0, 0));
    end
    while (stim_q.size() != 0) begin
      {set, start, pause, abort, auto_reload, load_val} = stim_q.pop_front();
      tick();
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL random_one_shot step=%0d {st,cnt,tc,dn,bsy,laps} got=%b want=%b", step, obs, want);
      end
      step++;
    end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    set         = 1'b1;
    start       = 1'b0;
    pause       = 1'b0;
    abort       = 1'b0;
    auto_reload = 1'b0;
    load_val    = 4'd0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause();
    test_same_cycle_cmds();
    test_load_zero();
    test_reset_mid_count();
    test_random_one_shot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
